modexp_ctrl: RTL and testbench

MODEXP_CTRL -- requirements
Module: modexp_ctrl

---
 rtl/modexp_pkg.sv | 37 +++
 rtl/modexp_ctrl_if.sv | 31 +++
 rtl/modexp_ctrl.sv | 132 +++++++++++++
 tb/tb_modexp_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared constants and state encoding for the modular-exponentiation controller.
package modexp_pkg;

   localparam int W  = 512;
   localparam int IW = 10;
   localparam int BW = $clog2(W);

   localparam logic [3:0] ST_IDLE       = 4'd0;
   localparam logic [3:0] ST_LOAD       = 4'd1;
   localparam logic [3:0] ST_SQ_START   = 4'd2;
   localparam logic [3:0] ST_SQ_WAIT    = 4'd3;
   localparam logic [3:0] ST_MUL_START  = 4'd4;
   localparam logic [3:0] ST_MUL_WAIT   = 4'd5;
   localparam logic [3:0] ST_NEXT       = 4'd6;
   localparam logic [3:0] ST_CONV_START = 4'd7;
   localparam logic [3:0] ST_CONV_WAIT  = 4'd8;
   localparam logic [3:0] ST_DONE       = 4'd9;

   typedef enum logic [3:0] {
      IDLE       = ST_IDLE,
      LOAD       = ST_LOAD,
      SQ_START   = ST_SQ_START,
      SQ_WAIT    = ST_SQ_WAIT,
      MUL_START  = ST_MUL_START,
      MUL_WAIT   = ST_MUL_WAIT,
      NEXT       = ST_NEXT,
      CONV_START = ST_CONV_START,
      CONV_WAIT  = ST_CONV_WAIT,
      DONE       = ST_DONE
   } state_t;

   // Exponent lengths beyond the operand width saturate to the full width.
   function automatic logic [IW-1:0] clamp_len(input logic [IW-1:0] len);
      return (len > IW'(W)) ? IW'(W) : len;
   endfunction

endpackage

// File: rtl/modexp_ctrl_if.sv
// Request/response and Montgomery-multiplier signals of the modexp controller.
interface modexp_ctrl_if;
   import modexp_pkg::*;

   logic          start;
   logic [W-1:0]  in_x;
   logic [W-1:0]  in_r;
   logic [W-1:0]  in_e;
   logic [IW-1:0] in_e_len;
   logic [W-1:0]  in_m;
   logic          mont_start;
   logic [W-1:0]  mont_a;
   logic [W-1:0]  mont_b;
   logic [W-1:0]  mont_m;
   logic [W-1:0]  mont_result;
   logic          mont_done;
   logic [W-1:0]  result;
   logic          done;
   logic          busy;

   modport slave (
      input  start, in_x, in_r, in_e, in_e_len, in_m, mont_result, mont_done,
      output mont_start, mont_a, mont_b, mont_m, result, done, busy
   );

   modport master (
      output start, in_x, in_r, in_e, in_e_len, in_m, mont_result, mont_done,
      input  mont_start, mont_a, mont_b, mont_m, result, done, busy
   );

endinterface

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// Latency: len + popcount(e) + 1 multiplier round trips plus ~3 cycles per bit; start ignored while busy.
module modexp_ctrl
   import modexp_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   modexp_ctrl_if.slave bus
);

   state_t        state, state_nxt;
   logic [W-1:0]  a_reg, x_reg, r_reg, e_reg, m_reg, res_reg;
   logic [IW-1:0] len_reg, i_reg;
   logic          e_bit;
   logic          mont_start;
   logic          done;
   logic          busy;
   logic [W-1:0]  op_b;

   assign e_bit = e_reg[i_reg[BW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         a_reg   <= '0;
         x_reg   <= '0;
         r_reg   <= '0;
         e_reg   <= '0;
         m_reg   <= '0;
         res_reg <= '0;
         len_reg <= '0;
         i_reg   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  x_reg   <= bus.in_x;
                  r_reg   <= bus.in_r;
                  e_reg   <= bus.in_e;
                  m_reg   <= bus.in_m;
                  len_reg <= clamp_len(bus.in_e_len);
               end
            end
            LOAD: begin
               a_reg <= r_reg;
               i_reg <= len_reg - IW'(1);
            end
            SQ_WAIT, MUL_WAIT: begin
               if (bus.mont_done) a_reg <= bus.mont_result;
            end
            NEXT: begin
               // Test before decrement so the index never wraps below zero.
               if (i_reg != '0) i_reg <= i_reg - IW'(1);
            end
            CONV_WAIT: begin
               if (bus.mont_done) begin
                  a_reg   <= bus.mont_result;
                  res_reg <= bus.mont_result;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt  = state;
      mont_start = 1'b0;
      done       = 1'b0;
      busy       = 1'b0;
      op_b       = a_reg;
      case (state)
         IDLE: begin
            if (bus.start) state_nxt = LOAD;
         end
         LOAD: begin
            busy      = 1'b1;
            state_nxt = (len_reg == '0) ? CONV_START : SQ_START;
         end
         SQ_START: begin
            busy       = 1'b1;
            mont_start = 1'b1;
            state_nxt  = SQ_WAIT;
         end
         SQ_WAIT: begin
            busy = 1'b1;
            if (bus.mont_done) state_nxt = e_bit ? MUL_START : NEXT;
         end
         MUL_START: begin
            busy       = 1'b1;
            mont_start = 1'b1;
            op_b       = x_reg;
            state_nxt  = MUL_WAIT;
         end
         MUL_WAIT: begin
            busy = 1'b1;
            op_b = x_reg;
            if (bus.mont_done) state_nxt = NEXT;
         end
         NEXT: begin
            busy      = 1'b1;
            state_nxt = (i_reg == '0) ? CONV_START : SQ_START;
         end
         CONV_START: begin
            busy       = 1'b1;
            mont_start = 1'b1;
            op_b       = W'(1);
            state_nxt  = CONV_WAIT;
         end
         CONV_WAIT: begin
            busy = 1'b1;
            op_b = W'(1);
            if (bus.mont_done) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.mont_start = mont_start;
   assign bus.mont_a     = a_reg;
   assign bus.mont_b     = op_b;
   assign bus.mont_m     = m_reg;
   assign bus.result     = res_reg;
   assign bus.done       = done;
   assign bus.busy       = busy;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Scoreboard bench for modexp_ctrl with a behavioural Montgomery multiplier (M = 1000003).
module tb_modexp_ctrl;
   import modexp_pkg::*;

   localparam longint unsigned M = 64'd1000003;

   typedef struct {
      logic [W-1:0] res;
      int           pulses;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   modexp_ctrl_if bus();

   modexp_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int              errors = 0;
   int              checks = 0;
   longint unsigned rmod, rinv;
   exp_t            sb[$];
   logic [W-1:0]    last_res;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   function automatic longint unsigned mulmod(input longint unsigned a, input longint unsigned b);
      return (a * b) % M;
   endfunction

   function automatic longint unsigned powmod(input longint unsigned b, input longint unsigned ex);
      longint unsigned r = 1, base = b % M, k = ex;
      while (k != 0) begin
         if (k[0]) r = mulmod(r, base);
         base = mulmod(base, base);
         k = k >> 1;
      end
      return r;
   endfunction

   function automatic longint unsigned mont(input longint unsigned a, input longint unsigned b);
      return mulmod(mulmod(a, b), rinv);
   endfunction

   // Plain X^E mod M, scanning exponent bits from the LSB upward.
   function automatic longint unsigned ref_exp(input longint unsigned x, input logic [W-1:0] e, input int len);
      longint unsigned r = 1 % M, base = x % M;
      for (int k = 0; k < len; k++) begin
         if (e[k]) r = mulmod(r, base);
         base = mulmod(base, base);
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] v;
      for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // Behavioural multiplier: returns a*b*R^-1 mod M after 5..20 cycles.
   initial begin : multiplier
      logic [W-1:0]    ca, cb, cm;
      longint unsigned mres;
      int              cnt;
      bit              pending;
      pending = 0;
      cnt = 0;
      mres = 0;
      bus.mont_done = 1'b0;
      bus.mont_result = '0;
      forever begin
         @(negedge clk);
         bus.mont_done = 1'b0;
         if (reset) begin
            pending = 0;
            continue;
         end
         if (pending) begin
            cnt--;
            if (cnt == 0) begin
               pending = 0;
               chk("mont_a held", bus.mont_a, ca);
               chk("mont_b held", bus.mont_b, cb);
               chk("mont_m held", bus.mont_m, cm);
               bus.mont_result = W'(mres);
               bus.mont_done = 1'b1;
            end
         end
         if (bus.mont_start) begin
            chk("mont_start while multiplier busy", W'(pending), W'(0));
            chk("mont_m is modulus", bus.mont_m, W'(M));
            ca = bus.mont_a;
            cb = bus.mont_b;
            cm = bus.mont_m;
            mres = mont(longint'(ca[63:0]) % M, longint'(cb[63:0]) % M);
            cnt = $urandom_range(5, 20);
            pending = 1;
         end
      end
   end

   initial begin : monitor
      int   pulses;
      exp_t ex;
      pulses = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pulses = 0;
            continue;
         end
         if (bus.mont_start) pulses++;
         if (bus.done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected done: result %0h with empty scoreboard", bus.result);
            end else begin
               ex = sb.pop_front();
               chk("result", bus.result, ex.res);
               chk("mont_start pulse count", W'(pulses), W'(ex.pulses));
            end
            pulses = 0;
         end
      end
   end

   task automatic scramble();
      bus.in_x = rand_w();
      bus.in_r = rand_w();
      bus.in_e = rand_w();
      bus.in_m = rand_w();
      bus.in_e_len = IW'($urandom);
   endtask

   // Called at a negedge; returns one negedge later with start dropped unless hold is set.
   task automatic start_op(input longint unsigned xn, input logic [W-1:0] e, input logic [IW-1:0] len,
                           input bit track, input longint want_res, input int want_pulses, input bit hold);
      exp_t ex;
      int   leff, pc;
      leff = (len > IW'(W)) ? W : int'(len);
      pc = 0;
      for (int k = 0; k < leff; k++) pc += int'(e[k]);
      ex.res = (want_res < 0) ? W'(ref_exp(xn, e, leff)) : W'(want_res);
      ex.pulses = (want_pulses < 0) ? leff + pc + 1 : want_pulses;
      if (track) sb.push_back(ex);
      last_res = ex.res;
      bus.in_x = W'(mulmod(xn, rmod));
      bus.in_r = W'(rmod);
      bus.in_e = e;
      bus.in_e_len = len;
      bus.in_m = W'(M);
      bus.start = 1'b1;
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      scramble();
   endtask

   task automatic wait_done();
      bit ok = 0;
      for (int c = 0; c < 40000; c++) begin
         if (bus.done) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      chk("done within cycle budget", W'(ok), W'(1));
   endtask

   task automatic run_and_hold(input longint unsigned xn, input logic [W-1:0] e, input logic [IW-1:0] len,
                               input longint want_res, input int want_pulses);
      start_op(xn, e, len, 1, want_res, want_pulses, 0);
      wait_done();
      @(negedge clk);
      chk("result held after done", bus.result, last_res);
   endtask

   initial begin : stim
      bit found;
      rmod = 1;
      for (int k = 0; k < W; k++) rmod = mulmod(rmod, 2);
      rinv = powmod(rmod, M - 2);
      bus.start = 1'b0;
      bus.in_x = '0;
      bus.in_r = '0;
      bus.in_e = '0;
      bus.in_e_len = '0;
      bus.in_m = '0;

      repeat (3) @(negedge clk);
      chk("reset busy", W'(bus.busy), W'(0));
      chk("reset done", W'(bus.done), W'(0));
      chk("reset mont_start", W'(bus.mont_start), W'(0));
      chk("reset result", bus.result, '0);
      chk("reset mont_m", bus.mont_m, '0);
      #1 reset = 1'b0;
      @(negedge clk);

      // Zero-length exponent: convert only.
      run_and_hold(longint'($urandom_range(1, 1000002)), rand_w(), 10'd0, 1, 1);
      run_and_hold(3, W'(1), 10'd1, 3, 3);
      run_and_hold(3, W'(11), 10'd4, 177147, 8);

      // Start held high for the whole operation.
      start_op(longint'($urandom_range(1, 1000002)), rand_w(), 10'd6, 1, -1, -1, 1);
      wait_done();
      bus.start = 1'b0;
      repeat (30) @(negedge clk);
      chk("start held: no second done", W'(sb.size()), W'(0));

      // Abandon an operation in MUL_WAIT.
      start_op(7, W'(3), 10'd2, 0, -1, -1, 0);
      found = 0;
      for (int c = 0; c < 400 && !found; c++) begin
         if (bus.mont_start && bus.mont_b !== bus.mont_a && bus.mont_b !== W'(1)) found = 1;
         else @(negedge clk);
      end
      chk("reached multiply step", W'(found), W'(1));
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("mid-op reset busy", W'(bus.busy), W'(0));
      chk("mid-op reset result", bus.result, '0);
      chk("mid-op reset mont_start", W'(bus.mont_start), W'(0));
      @(negedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      run_and_hold(5, W'(2), 10'd2, 25, 4);

      // Back-to-back: start in the IDLE cycle right after done.
      start_op(longint'($urandom_range(1, 1000002)), rand_w(), 10'd9, 1, -1, -1, 0);
      wait_done();
      chk("busy low in done cycle", W'(bus.busy), W'(0));
      @(negedge clk);
      chk("busy low in idle cycle", W'(bus.busy), W'(0));
      start_op(longint'($urandom_range(1, 1000002)), rand_w(), 10'd12, 1, -1, -1, 0);
      chk("busy high after restart", W'(bus.busy), W'(1));
      wait_done();
      @(negedge clk);

      for (int n = 0; n < 6; n++)
         run_and_hold(longint'($urandom_range(1, 1000002)), rand_w(), IW'($urandom_range(0, 24)), -1, -1);

      // Over-range length saturates to the full operand width.
      run_and_hold(longint'($urandom_range(1, 1000002)), rand_w(), 10'd700, -1, -1);

      repeat (30) @(negedge clk);
      chk("scoreboard drained", W'(sb.size()), W'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
